// File: rtl/fp_wire_pkg.sv
// Shared types for the fp_unit result-checking path: checker FSM states,
// the queued expected-entry layout and the canonical quiet NaN constant.
package fp_wire;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fp_check_state_type;

    localparam logic [31:0] FP_CANON_NAN = 32'h7FC00000;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  flags;
        logic        nanmask;
    } fp_check_entry_type;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFFFFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/fp_check_fifo.sv
// Synchronous FIFO of expected entries; head is visible combinationally so the
// checker can compare and pop it on the same edge that a result arrives.
module fp_check_fifo
    import fp_wire::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  fp_check_entry_type push_data,
    input  logic               pop,
    output fp_check_entry_type head_data,
    output logic               full,
    output logic               empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    fp_check_entry_type mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          wr_en;
    logic          rd_en;

    assign full      = (count_reg == (AW+1)'(DEPTH));
    assign empty     = (count_reg == '0);
    assign count     = count_reg;
    assign wr_en     = push && !full;
    assign rd_en     = pop && !empty;
    assign head_data = mem_reg[rd_ptr_reg];

    // Storage carries no reset: a slot is only read after it has been written.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clock) begin
                if (wr_en && (wr_ptr_reg == AW'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/fp_result_checker.sv
// Response-side checker for fp_unit: queues expected {result, flags} at issue
// time, compares each returned result in order, counts and captures first failure.
module fp_result_checker
    import fp_wire::*;
#(
    parameter int DEPTH        = 4,
    parameter bit HALT_ON_FAIL = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        exp_valid,
    output logic        exp_ready,
    input  logic [31:0] exp_result,
    input  logic [4:0]  exp_flags,
    input  logic        exp_nanmask,
    input  logic        res_valid,
    input  logic [31:0] res_result,
    input  logic [4:0]  res_flags,
    output logic [31:0] pass_cnt,
    output logic [31:0] fail_cnt,
    output logic        fail_seen,
    output logic        underflow,
    output logic [31:0] fail_index,
    output logic [36:0] fail_exp,
    output logic [36:0] fail_calc,
    output logic        done
);

    localparam int CW = $clog2(DEPTH) + 1;

    fp_check_state_type state_reg;
    logic [31:0] pass_cnt_reg;
    logic [31:0] fail_cnt_reg;
    logic        fail_seen_reg;
    logic        underflow_reg;
    logic [31:0] fail_index_reg;
    logic [36:0] fail_exp_reg;
    logic [36:0] fail_calc_reg;

    fp_check_entry_type push_entry;
    fp_check_entry_type head_entry;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    logic        push_en;
    logic        cmp_en;
    logic        pop_en;
    logic        underflow_ev;
    logic [31:0] rdiff;
    logic [4:0]  fdiff;
    logic        match;
    logic        pass_ev;
    logic        fail_ev;
    logic        drain_empty;
    logic        halt_ev;

    assign push_entry = '{result: exp_result, flags: exp_flags, nanmask: exp_nanmask};

    fp_check_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (start),
        .push      (push_en),
        .push_data (push_entry),
        .pop       (pop_en),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign exp_ready = (state_reg == RUN) && !fifo_full;
    assign done      = (state_reg == DONE);

    // Results are matched only against entries queued on earlier edges: the
    // empty check uses the occupancy at the start of the cycle.
    always_comb begin
        push_en      = exp_valid && exp_ready && !start;
        cmp_en       = res_valid && !start && ((state_reg == RUN) || (state_reg == DRAIN));
        pop_en       = cmp_en && !fifo_empty;
        underflow_ev = cmp_en && fifo_empty;

        rdiff = head_entry.result ^ res_result;
        fdiff = head_entry.flags ^ res_flags;
        // A canonical NaN result matches any expected NaN regardless of sign/payload.
        if (head_entry.nanmask && (res_result == FP_CANON_NAN)) begin
            rdiff[21:0] = '0;
            rdiff[31]   = 1'b0;
        end
        match = (rdiff == '0) && (fdiff == '0);

        pass_ev     = pop_en && match;
        fail_ev     = (pop_en && !match) || underflow_ev;
        halt_ev     = fail_ev && HALT_ON_FAIL;
        drain_empty = fifo_empty || ((fifo_count == CW'(1)) && pop_en);
    end

    always_ff @(posedge clock) begin
        if (reset || start) begin
            state_reg      <= reset ? IDLE : RUN;
            pass_cnt_reg   <= '0;
            fail_cnt_reg   <= '0;
            fail_seen_reg  <= 1'b0;
            underflow_reg  <= 1'b0;
            fail_index_reg <= '0;
            fail_exp_reg   <= '0;
            fail_calc_reg  <= '0;
        end else begin
            if (pass_ev) begin
                pass_cnt_reg <= sat_inc(pass_cnt_reg);
            end
            if (fail_ev) begin
                fail_cnt_reg  <= sat_inc(fail_cnt_reg);
                fail_seen_reg <= 1'b1;
            end
            if (underflow_ev) begin
                underflow_reg <= 1'b1;
            end
            if (fail_ev && !fail_seen_reg) begin
                fail_index_reg <= pass_cnt_reg + fail_cnt_reg;
                fail_exp_reg   <= underflow_ev ? 37'd0 : {head_entry.result, head_entry.flags};
                fail_calc_reg  <= {res_result, res_flags};
            end

            case (state_reg)
                IDLE: state_reg <= IDLE;
                RUN: begin
                    if (stop) begin
                        state_reg <= DRAIN;
                    end else if (halt_ev) begin
                        state_reg <= DONE;
                    end
                end
                DRAIN: begin
                    if (halt_ev || drain_empty) begin
                        state_reg <= DONE;
                    end
                end
                DONE:    state_reg <= DONE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign pass_cnt   = pass_cnt_reg;
    assign fail_cnt   = fail_cnt_reg;
    assign fail_seen  = fail_seen_reg;
    assign underflow  = underflow_reg;
    assign fail_index = fail_index_reg;
    assign fail_exp   = fail_exp_reg;
    assign fail_calc  = fail_calc_reg;

endmodule

// File: tb/tb_fp_result_checker.sv
// Directed bench for fp_result_checker: one halting and one non-halting instance
// share the same stimulus so both failure policies are observed.
module tb_fp_result_checker;

    logic        clock = 1'b0;
    logic        reset, start, stop;
    logic        exp_valid, exp_nanmask, res_valid;
    logic [31:0] exp_result, res_result;
    logic [4:0]  exp_flags, res_flags;

    logic        exp_ready_h, fail_seen_h, underflow_h, done_h;
    logic [31:0] pass_cnt_h, fail_cnt_h, fail_index_h;
    logic [36:0] fail_exp_h, fail_calc_h;
    logic        exp_ready_n, fail_seen_n, underflow_n, done_n;
    logic [31:0] pass_cnt_n, fail_cnt_n, fail_index_n;
    logic [36:0] fail_exp_n, fail_calc_n;

    int checks = 0;
    int passes = 0;

    always #5 clock = ~clock;

    fp_result_checker #(.DEPTH(4), .HALT_ON_FAIL(1'b1)) u_dut_h (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .exp_valid(exp_valid), .exp_ready(exp_ready_h), .exp_result(exp_result),
        .exp_flags(exp_flags), .exp_nanmask(exp_nanmask),
        .res_valid(res_valid), .res_result(res_result), .res_flags(res_flags),
        .pass_cnt(pass_cnt_h), .fail_cnt(fail_cnt_h), .fail_seen(fail_seen_h),
        .underflow(underflow_h), .fail_index(fail_index_h), .fail_exp(fail_exp_h),
        .fail_calc(fail_calc_h), .done(done_h)
    );

    fp_result_checker #(.DEPTH(4), .HALT_ON_FAIL(1'b0)) u_dut_n (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .exp_valid(exp_valid), .exp_ready(exp_ready_n), .exp_result(exp_result),
        .exp_flags(exp_flags), .exp_nanmask(exp_nanmask),
        .res_valid(res_valid), .res_result(res_result), .res_flags(res_flags),
        .pass_cnt(pass_cnt_n), .fail_cnt(fail_cnt_n), .fail_seen(fail_seen_n),
        .underflow(underflow_n), .fail_index(fail_index_n), .fail_exp(fail_exp_n),
        .fail_calc(fail_calc_n), .done(done_n)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic push(input logic [31:0] r, input logic [4:0] f, input logic m);
        exp_valid = 1'b1; exp_result = r; exp_flags = f; exp_nanmask = m;
        step();
        exp_valid = 1'b0;
        $display("push   result=%h flags=%h mask=%0d", r, f, m);
    endtask

    task automatic result(input logic [31:0] r, input logic [4:0] f);
        res_valid = 1'b1; res_result = r; res_flags = f;
        step();
        res_valid = 1'b0;
        $display("result result=%h flags=%h pass_h=%0d fail_h=%0d", r, f, pass_cnt_h, fail_cnt_h);
    endtask

    task automatic test_reset();
        logic [197:0] all_h;
        all_h = {pass_cnt_h, fail_cnt_h, fail_index_h, fail_exp_h, fail_calc_h,
                 exp_ready_h, fail_seen_h, underflow_h, done_h};
        checks++;
        if (all_h !== '0) $display("FAIL reset_outputs got %h want 0", all_h);
        else passes++;
    endtask

    task automatic test_basic();
        pulse_start();
        for (int i = 0; i < 3; i++) push(32'h3F800000, 5'h00, 1'b0);
        for (int i = 0; i < 3; i++) result(32'h3F800000, 5'h00);
        checks++;
        if ({pass_cnt_h, fail_cnt_h} !== {32'd3, 32'd0})
            $display("FAIL basic_counts got %0d/%0d want 3/0", pass_cnt_h, fail_cnt_h);
        else passes++;
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if (done_h !== 1'b0) $display("FAIL basic_drain_done got %b want 0", done_h);
        else passes++;
        step();
        checks++;
        if (done_h !== 1'b1) $display("FAIL basic_done got %b want 1", done_h);
        else passes++;
    endtask

    task automatic test_halt();
        pulse_start();
        push(32'h00000001, 5'h00, 1'b0);
        result(32'h00000000, 5'h00);
        checks++;
        if ({fail_cnt_h, fail_index_h, fail_seen_h, done_h} !== {32'd1, 32'd0, 1'b1, 1'b1})
            $display("FAIL halt_state got cnt=%0d idx=%0d seen=%b done=%b want 1/0/1/1",
                     fail_cnt_h, fail_index_h, fail_seen_h, done_h);
        else passes++;
        checks++;
        if ({fail_exp_h, fail_calc_h} !== {37'h00000001_0 >> 0 == 0 ? 37'd0 : {32'h00000001, 5'h00}, 37'd0})
            $display("FAIL halt_capture got exp=%h calc=%h want %h/0", fail_exp_h, fail_calc_h,
                     {32'h00000001, 5'h00});
        else passes++;
        checks++;
        if ({fail_cnt_n, done_n} !== {32'd1, 1'b0})
            $display("FAIL nohalt_keeps_running got cnt=%0d done=%b want 1/0", fail_cnt_n, done_n);
        else passes++;
        result(32'h00000000, 5'h00);
        checks++;
        if ({pass_cnt_h, fail_cnt_h} !== {32'd0, 32'd1})
            $display("FAIL halt_ignores_res got %0d/%0d want 0/1", pass_cnt_h, fail_cnt_h);
        else passes++;
    endtask

    task automatic test_nanmask();
        pulse_start();
        push(32'hFFC00001, 5'h10, 1'b1);
        result(32'h7FC00000, 5'h10);
        checks++;
        if ({pass_cnt_h, fail_cnt_h} !== {32'd1, 32'd0})
            $display("FAIL nan_masked got %0d/%0d want 1/0", pass_cnt_h, fail_cnt_h);
        else passes++;
        push(32'hFFC00001, 5'h10, 1'b0);
        result(32'h7FC00000, 5'h10);
        checks++;
        if ({fail_cnt_h, fail_index_h, fail_calc_h} !== {32'd1, 32'd1, 32'h7FC00000, 5'h10})
            $display("FAIL nan_unmasked got cnt=%0d idx=%0d calc=%h want 1/1/%h",
                     fail_cnt_h, fail_index_h, fail_calc_h, {32'h7FC00000, 5'h10});
        else passes++;
        checks++;
        if (fail_exp_h !== {32'hFFC00001, 5'h10})
            $display("FAIL nan_fail_exp got %h want %h", fail_exp_h, {32'hFFC00001, 5'h10});
        else passes++;
    endtask

    task automatic test_underflow();
        pulse_start();
        exp_valid = 1'b1; exp_result = 32'h40000000; exp_flags = 5'h01; exp_nanmask = 1'b0;
        res_valid = 1'b1; res_result = 32'h40000000; res_flags = 5'h01;
        step();
        exp_valid = 1'b0; res_valid = 1'b0;
        $display("push+result on empty fifo result=40000000");
        checks++;
        if ({underflow_h, fail_cnt_h, fail_index_h, done_h} !== {1'b1, 32'd1, 32'd0, 1'b1})
            $display("FAIL underflow_halt got uf=%b cnt=%0d idx=%0d done=%b want 1/1/0/1",
                     underflow_h, fail_cnt_h, fail_index_h, done_h);
        else passes++;
        checks++;
        if ({fail_exp_h, fail_calc_h} !== {37'd0, 32'h40000000, 5'h01})
            $display("FAIL underflow_capture got exp=%h calc=%h want 0/%h",
                     fail_exp_h, fail_calc_h, {32'h40000000, 5'h01});
        else passes++;
        result(32'h40000000, 5'h01);
        checks++;
        if ({underflow_n, pass_cnt_n, fail_cnt_n} !== {1'b1, 32'd1, 32'd1})
            $display("FAIL underflow_entry_kept got uf=%b pass=%0d fail=%0d want 1/1/1",
                     underflow_n, pass_cnt_n, fail_cnt_n);
        else passes++;
        result(32'h40000000, 5'h01);
        checks++;
        if ({pass_cnt_n, fail_cnt_n} !== {32'd1, 32'd2})
            $display("FAIL underflow_occupancy_one got %0d/%0d want 1/2", pass_cnt_n, fail_cnt_n);
        else passes++;
    endtask

    task automatic test_back_to_back();
        pulse_start();
        push(32'hA0000000, 5'h00, 1'b0);
        push(32'hA0000001, 5'h01, 1'b0);
        push(32'hA0000002, 5'h02, 1'b0);
        // Push D while popping A: occupancy stays at three.
        exp_valid = 1'b1; exp_result = 32'hA0000003; exp_flags = 5'h04; exp_nanmask = 1'b0;
        res_valid = 1'b1; res_result = 32'hA0000000; res_flags = 5'h00;
        step();
        exp_valid = 1'b0; res_valid = 1'b0;
        $display("push+pop push=A0000003 pop=A0000000");
        checks++;
        if ({exp_ready_h, pass_cnt_h} !== {1'b1, 32'd1})
            $display("FAIL b2b_count3 got ready=%b pass=%0d want 1/1", exp_ready_h, pass_cnt_h);
        else passes++;
        push(32'hA0000004, 5'h08, 1'b0);
        checks++;
        if (exp_ready_h !== 1'b0) $display("FAIL b2b_full got ready=%b want 0", exp_ready_h);
        else passes++;
        result(32'hA0000001, 5'h01);
        result(32'hA0000002, 5'h02);
        result(32'hA0000003, 5'h04);
        result(32'hA0000004, 5'h08);
        checks++;
        if ({pass_cnt_h, fail_cnt_h, exp_ready_h} !== {32'd5, 32'd0, 1'b1})
            $display("FAIL b2b_order got pass=%0d fail=%0d ready=%b want 5/0/1",
                     pass_cnt_h, fail_cnt_h, exp_ready_h);
        else passes++;
    endtask

    task automatic test_reset_mid();
        logic [197:0] all_h;
        pulse_start();
        push(32'h11111111, 5'h00, 1'b0);
        push(32'h22222222, 5'h00, 1'b0);
        push(32'h33333333, 5'h00, 1'b0);
        result(32'h11111111, 5'h00);
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if ({exp_ready_h, done_h, pass_cnt_h} !== {1'b0, 1'b0, 32'd1})
            $display("FAIL drain_entry got ready=%b done=%b pass=%0d want 0/0/1",
                     exp_ready_h, done_h, pass_cnt_h);
        else passes++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        all_h = {pass_cnt_h, fail_cnt_h, fail_index_h, fail_exp_h, fail_calc_h,
                 exp_ready_h, fail_seen_h, underflow_h, done_h};
        checks++;
        if (all_h !== '0) $display("FAIL reset_mid_outputs got %h want 0", all_h);
        else passes++;
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        checks++;
        if ({exp_ready_h, done_h} !== {1'b1, 1'b0})
            $display("FAIL start_over_stop got ready=%b done=%b want 1/0", exp_ready_h, done_h);
        else passes++;
        result(32'h22222222, 5'h00);
        checks++;
        if ({underflow_h, pass_cnt_h} !== {1'b1, 32'd0})
            $display("FAIL reset_flushed_fifo got uf=%b pass=%0d want 1/0", underflow_h, pass_cnt_h);
        else passes++;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        exp_valid = 1'b0; exp_result = '0; exp_flags = '0; exp_nanmask = 1'b0;
        res_valid = 1'b0; res_result = '0; res_flags = '0;
        step();
        step();
        reset = 1'b0;
        step();
        test_reset();
        test_basic();
        test_halt();
        test_nanmask();
        test_underflow();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
